// File: rtl/rsv_pkg.sv
// Shared router select definitions for the 6-way mux and demux.
// Port numbering and the 3-bit select encoding live here.
package rsv_pkg;

    localparam int NUM_PORTS = 6;
    localparam int SEL_WIDTH = 3;

    typedef logic [SEL_WIDTH-1:0] sel_t;
    typedef logic [2:0]           port_t;

    localparam port_t PORT_A = 3'd0;
    localparam port_t PORT_B = 3'd1;
    localparam port_t PORT_C = 3'd2;
    localparam port_t PORT_D = 3'd3;
    localparam port_t PORT_E = 3'd4;
    localparam port_t PORT_F = 3'd5;

    // sel[1] is a don't-care once sel[2] picks the E/F pair.
    function automatic port_t sel_to_port(input sel_t sel);
        port_t p;
        unique case (1'b1)
            sel[2] &  sel[0]: p = PORT_F;
            sel[2] & ~sel[0]: p = PORT_E;
            default:          p = {1'b0, sel[1:0]};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/demux_fifo.sv
// Single-clock FIFO for one demux output port.
// Head entry is always visible on head; storage clears on reset.
module demux_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointers are power-of-two wide, so plain increment wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux1to6_buf.sv
// Buffered 1-to-6 flit distributor with one FIFO per output port.
// in_ready looks only at the addressed FIFO; pops give no same-cycle credit.
module demux1to6_buf
    import rsv_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [SEL_WIDTH-1:0]     in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_PORTS*WIDTH-1:0] out_data,
    output logic [NUM_PORTS-1:0]     out_valid,
    input  logic [NUM_PORTS-1:0]     out_ready
);

    port_t                idx;
    logic [NUM_PORTS-1:0] hit;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;

    assign idx = sel_to_port(in_sel);

    always_comb begin
        hit = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            hit[k] = (idx == 3'(k));
        end
    end

    assign in_ready  = |(hit & ~full);
    assign push      = hit & {NUM_PORTS{in_valid & in_ready}};
    assign out_valid = ~empty;

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        demux_fifo #(
            .WIDTH(WIDTH),
            .DEPTH(DEPTH)
        ) u_fifo (
            .clk  (clk),
            .rst_n(rst_n),
            .push (push[k]),
            .wdata(in_data),
            .pop  (out_ready[k]),
            .head (out_data[k*WIDTH +: WIDTH]),
            .full (full[k]),
            .empty(empty[k])
        );
    end

endmodule
